pic_ctrl_unit: RTL and testbench

Clocked, parametrised control unit for the programmable interrupt controller. Decodes the ICW1–ICW4 initialisation sequence and OCW1–OCW3 writes from the CPU bus interface. Sequences the INTA cycle in 8086 mode (2 pulses) and 8080 mode (3 pulses, CALL opcode), driving vector bytes onto the data bus. Generates end-of-interrupt (EOI) strobes, both automatic and command-driven, for the in-service logic.

---
 rtl/pic_ctrl_unit_if.sv | 31 +++
 rtl/pic_ctrl_unit.sv | 208 ++++++++++++++++++++
 tb/tb_pic_ctrl_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_ctrl_unit_if.sv
// rtl/pic_ctrl_unit_if.sv - CPU bus, INTA and EOI signal bundle for pic_ctrl_unit
interface pic_ctrl_unit_if #(
  parameter int N_IRQ = 8
);
  localparam int LW = $clog2(N_IRQ);

  logic             wr_p;
  logic             a0;
  logic [7:0]       din;
  logic             inta_n;
  logic [N_IRQ-1:0] isr;
  logic [7:0]       dout;
  logic             vec_oe;
  logic [N_IRQ-1:0] imr;
  logic             init_done;
  logic             mode_8086;
  logic             aeoi;
  logic             read_isr;
  logic             eoi_p;
  logic [LW-1:0]    eoi_lvl;

  modport master (
    output wr_p, a0, din, inta_n, isr,
    input  dout, vec_oe, imr, init_done, mode_8086, aeoi, read_isr, eoi_p, eoi_lvl
  );

  modport slave (
    input  wr_p, a0, din, inta_n, isr,
    output dout, vec_oe, imr, init_done, mode_8086, aeoi, read_isr, eoi_p, eoi_lvl
  );
endinterface

// File: rtl/pic_ctrl_unit.sv
// rtl/pic_ctrl_unit.sv - PIC control unit: ICW/OCW decode, INTA vector sequencing, EOI strobes
module pic_ctrl_unit #(
  parameter int          N_IRQ   = 8,
  parameter logic [7:0]  IMR_RST = 8'h00,
  localparam int         LW      = $clog2(N_IRQ)
) (
  input  logic           clk,
  input  logic           reset_n,
  pic_ctrl_unit_if.slave bus
);

  typedef enum logic [2:0] {UNINIT, W2, W3, W4, READY} init_state_t;
  typedef enum logic [1:0] {A_IDLE, A_P1, A_P2, A_P3} ack_state_t;

  init_state_t      init_q, init_d;
  ack_state_t       ack_q, ack_d;

  logic [2:0]       icw1_hi_q;
  logic             icw1_adi_q, icw1_sngl_q, icw1_ic4_q;
  logic [7:0]       icw2_q;
  logic             mode_q, aeoi_q;
  logic [N_IRQ-1:0] imr_q;
  logic             init_done_q, read_isr_q;
  logic             inta_q;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [7:0]       dout_q, dout_d;
  logic             vec_oe_q, vec_oe_d;
  logic             eoi_p_q;
  logic [LW-1:0]    eoi_lvl_q;
  logic             pend_q;
  logic [LW-1:0]    pend_lvl_q;

  function automatic logic [LW-1:0] lowest_set(input logic [N_IRQ-1:0] v);
    lowest_set = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (v[i]) lowest_set = LW'(i);
  endfunction

  logic          wr_icw1, wr_ocw2, ocw_eoi, inta_fall, inta_rise, aeoi_fire;
  logic [LW-1:0] ocw_lvl, isr_lvl;
  logic [2:0]    lvl3;
  logic [7:0]    vec_8086, addr_lo;

  assign wr_icw1   = bus.wr_p && !bus.a0 && bus.din[4];
  assign wr_ocw2   = bus.wr_p && !bus.a0 && (init_q == READY) && (bus.din[4:3] == 2'b00);
  assign ocw_eoi   = wr_ocw2 && (((bus.din[7:5] == 3'b001) && (|bus.isr)) ||
                                 (bus.din[7:5] == 3'b011));
  assign ocw_lvl   = (bus.din[7:5] == 3'b011) ? bus.din[LW-1:0] : lowest_set(bus.isr);
  assign inta_fall = inta_q && !bus.inta_n;
  assign inta_rise = !inta_q && bus.inta_n;
  // An empty ISR at the level-latch edge reports the lowest-priority level
  assign isr_lvl   = (|bus.isr) ? lowest_set(bus.isr) : LW'(N_IRQ - 1);
  assign lvl3      = 3'(isr_lvl);
  assign vec_8086  = {icw2_q[7:LW], isr_lvl};
  assign addr_lo   = icw1_adi_q ? {icw1_hi_q, lvl3, 2'b00} : {icw1_hi_q[2:1], lvl3, 3'b000};

  always_comb begin
    init_d = init_q;
    if (wr_icw1) begin
      init_d = W2;
    end else if (bus.wr_p && bus.a0) begin
      case (init_q)
        W2:      init_d = !icw1_sngl_q ? W3 : (icw1_ic4_q ? W4 : READY);
        W3:      init_d = icw1_ic4_q ? W4 : READY;
        W4:      init_d = READY;
        default: init_d = init_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q      <= UNINIT;
      icw1_hi_q   <= '0;
      icw1_adi_q  <= 1'b0;
      icw1_sngl_q <= 1'b0;
      icw1_ic4_q  <= 1'b0;
      icw2_q      <= '0;
      mode_q      <= 1'b0;
      aeoi_q      <= 1'b0;
      imr_q       <= IMR_RST[N_IRQ-1:0];
      init_done_q <= 1'b0;
      read_isr_q  <= 1'b0;
    end else begin
      init_q      <= init_d;
      init_done_q <= (init_d == READY);
      if (wr_icw1) begin
        icw1_hi_q   <= bus.din[7:5];
        icw1_adi_q  <= bus.din[2];
        icw1_sngl_q <= bus.din[1];
        icw1_ic4_q  <= bus.din[0];
        mode_q      <= 1'b0;
        aeoi_q      <= 1'b0;
        imr_q       <= IMR_RST[N_IRQ-1:0];
      end else if (bus.wr_p && bus.a0) begin
        case (init_q)
          W2:      icw2_q <= bus.din;
          W4: begin
            mode_q <= bus.din[0];
            aeoi_q <= bus.din[1];
          end
          READY:   imr_q <= bus.din[N_IRQ-1:0];
          default: ;
        endcase
      end else if (bus.wr_p && (init_q == READY) && (bus.din[4:3] == 2'b01) && bus.din[1]) begin
        read_isr_q <= bus.din[0];
      end
    end
  end

  always_comb begin
    ack_d     = ack_q;
    vec_oe_d  = vec_oe_q;
    dout_d    = dout_q;
    lvl_d     = lvl_q;
    aeoi_fire = 1'b0;
    if (wr_icw1) begin
      ack_d    = A_IDLE;
      vec_oe_d = 1'b0;
      dout_d   = '0;
    end else if (init_done_q) begin
      if (inta_fall) begin
        case (ack_q)
          A_IDLE: begin
            ack_d    = A_P1;
            vec_oe_d = !mode_q;
            dout_d   = mode_q ? 8'h00 : 8'hCD;
          end
          A_P1: begin
            ack_d    = A_P2;
            lvl_d    = isr_lvl;
            vec_oe_d = 1'b1;
            dout_d   = mode_q ? vec_8086 : addr_lo;
          end
          A_P2: begin
            if (!mode_q) begin
              ack_d    = A_P3;
              vec_oe_d = 1'b1;
              dout_d   = icw2_q;
            end
          end
          default: ;
        endcase
      end else if (inta_rise) begin
        vec_oe_d = 1'b0;
        dout_d   = '0;
        if ((ack_q == A_P3) || ((ack_q == A_P2) && mode_q)) begin
          ack_d     = A_IDLE;
          aeoi_fire = aeoi_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q    <= A_IDLE;
      vec_oe_q <= 1'b0;
      dout_q   <= '0;
      lvl_q    <= '0;
      inta_q   <= 1'b1;
    end else begin
      ack_q    <= ack_d;
      vec_oe_q <= vec_oe_d;
      dout_q   <= dout_d;
      lvl_q    <= lvl_d;
      inta_q   <= bus.inta_n;
    end
  end

  // A command EOI owns its cycle; a coincident AEOI is parked and issued next
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eoi_p_q    <= 1'b0;
      eoi_lvl_q  <= '0;
      pend_q     <= 1'b0;
      pend_lvl_q <= '0;
    end else if (ocw_eoi) begin
      eoi_p_q   <= 1'b1;
      eoi_lvl_q <= ocw_lvl;
      if (aeoi_fire) begin
        pend_q     <= 1'b1;
        pend_lvl_q <= lvl_q;
      end
    end else if (pend_q) begin
      eoi_p_q    <= 1'b1;
      eoi_lvl_q  <= pend_lvl_q;
      pend_q     <= aeoi_fire;
      pend_lvl_q <= lvl_q;
    end else if (aeoi_fire) begin
      eoi_p_q   <= 1'b1;
      eoi_lvl_q <= lvl_q;
    end else begin
      eoi_p_q <= 1'b0;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.vec_oe    = vec_oe_q;
  assign bus.imr       = imr_q;
  assign bus.init_done = init_done_q;
  assign bus.mode_8086 = mode_q;
  assign bus.aeoi      = aeoi_q;
  assign bus.read_isr  = read_isr_q;
  assign bus.eoi_p     = eoi_p_q;
  assign bus.eoi_lvl   = eoi_lvl_q;

endmodule

// File: tb/tb_pic_ctrl_unit.sv
// tb/tb_pic_ctrl_unit.sv - self-checking bench for pic_ctrl_unit
module tb_pic_ctrl_unit;

  localparam logic [7:0] IMR0 = 8'h5A;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pic_ctrl_unit_if #(.N_IRQ(8)) b0();
  pic_ctrl_unit_if #(.N_IRQ(4)) b1();

  pic_ctrl_unit #(.N_IRQ(8), .IMR_RST(IMR0)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(b0));
  pic_ctrl_unit #(.N_IRQ(4), .IMR_RST(8'hF3)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(b1));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  logic       cur_inta = 1'b1;
  logic [7:0] cur_isr  = 8'h00;

  // Reference model: pending-ICW list, pulse counter and an EOI queue
  logic [7:0] m_icw1, m_icw2, m_icw4, m_imr;
  bit         m_ready, m_read_isr, m_low, m_prev, e_eoi;
  int         m_pulse, m_lvl, e_lvl;
  int         need[$];
  int         eoiq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int low_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_icw1 = 0; m_icw2 = 0; m_icw4 = 0; m_imr = IMR0;
    m_ready = 0; m_read_isr = 0; m_low = 0; m_prev = 1; e_eoi = 0;
    m_pulse = 0; m_lvl = 0; e_lvl = 0;
    need.delete();
    eoiq.delete();
  endtask

  function automatic logic exp_vec();
    return m_low && !(m_icw4[0] && m_pulse == 1);
  endfunction

  function automatic logic [7:0] exp_dout();
    if (!exp_vec()) return 8'h00;
    if (m_icw4[0]) return 8'({m_icw2[7:3], 3'b000} + m_lvl);
    case (m_pulse)
      1: return 8'hCD;
      2: return m_icw1[2] ? 8'({m_icw1[7:5], 5'b0} + m_lvl * 4)
                          : 8'({m_icw1[7:6], 6'b0} + m_lvl * 8);
      default: return m_icw2;
    endcase
  endfunction

  task automatic model_step(input logic wr, input logic a0, input logic [7:0] d,
                            input logic inta, input logic [7:0] isr);
    bit fall, rise, was_ready;
    int k, final_p;
    if (!reset_n) begin
      model_reset();
      return;
    end
    fall = m_prev && !inta;
    rise = !m_prev && inta;
    m_prev = inta;
    was_ready = m_ready;
    if (wr && !a0 && d[4]) begin
      m_icw1 = d; m_icw4 = 0; m_imr = IMR0; m_ready = 0; m_pulse = 0; m_low = 0;
      need.delete();
      need.push_back(2);
      if (!d[1]) need.push_back(3);
      if (d[0]) need.push_back(4);
    end else begin
      if (wr && need.size() > 0) begin
        if (a0) begin
          k = need.pop_front();
          if (k == 2) m_icw2 = d;
          else if (k == 4) m_icw4 = d;
          if (need.size() == 0) m_ready = 1;
        end
      end else if (wr && m_ready) begin
        if (a0) m_imr = d;
        else if (d[4:3] == 2'b00) begin
          if (d[7:5] == 3'd1 && isr != 0) eoiq.push_front(low_idx(isr));
          else if (d[7:5] == 3'd3) eoiq.push_front(int'(d[2:0]));
        end else if (d[4:3] == 2'b01 && d[1]) m_read_isr = d[0];
      end
      if (was_ready) begin
        final_p = m_icw4[0] ? 2 : 3;
        if (fall) begin
          m_pulse++;
          m_low = 1;
          if (m_pulse == 2) m_lvl = (isr == 0) ? 7 : low_idx(isr);
        end else if (rise && m_low) begin
          m_low = 0;
          if (m_pulse == final_p) begin
            m_pulse = 0;
            if (m_icw4[1]) eoiq.push_back(m_lvl);
          end
        end
      end
    end
    if (eoiq.size() > 0) begin
      e_eoi = 1;
      e_lvl = eoiq.pop_front();
    end else begin
      e_eoi = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("vec_oe", 32'(b0.vec_oe), 32'(exp_vec()));
      check("dout", 32'(b0.dout), 32'(exp_dout()));
      check("imr", 32'(b0.imr), 32'(m_imr));
      check("init_done", 32'(b0.init_done), 32'(m_ready));
      check("mode_8086", 32'(b0.mode_8086), 32'(m_icw4[0]));
      check("aeoi", 32'(b0.aeoi), 32'(m_icw4[1]));
      check("read_isr", 32'(b0.read_isr), 32'(m_read_isr));
      check("eoi_p", 32'(b0.eoi_p), 32'(e_eoi));
      if (e_eoi) check("eoi_lvl", 32'(b0.eoi_lvl), 32'(e_lvl));
    end
  end

  task automatic step(input logic wr, input logic a0, input logic [7:0] d);
    b0.wr_p = wr; b0.a0 = a0; b0.din = d; b0.inta_n = cur_inta; b0.isr = cur_isr;
    b1.wr_p = wr; b1.a0 = a0; b1.din = d; b1.inta_n = cur_inta; b1.isr = cur_isr[3:0];
    @(posedge clk);
    model_step(wr, a0, d, cur_inta, cur_isr);
    @(negedge clk);
    b0.wr_p = 1'b0;
    b1.wr_p = 1'b0;
  endtask

  task automatic wr(input logic a0, input logic [7:0] d);
    step(1'b1, a0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic lo();
    cur_inta = 1'b0;
    idle(1);
  endtask

  task automatic hi();
    cur_inta = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    b0.wr_p = 0; b0.a0 = 0; b0.din = 0; b0.inta_n = 1; b0.isr = 0;
    b1.wr_p = 0; b1.a0 = 0; b1.din = 0; b1.inta_n = 1; b1.isr = 0;
    chk_en = 1;
    idle(3);
    check("rst_imr8", 32'(b0.imr), 32'h5A);
    check("rst_imr4", 32'(b1.imr), 32'h3);
    check("rst_vec_oe", 32'(b0.vec_oe), 32'h0);
    reset_n = 1'b1;
    idle(2);

    // INTA before initialisation
    lo(); check("preinit_vec_oe", 32'(b0.vec_oe), 32'h0);
    hi(); idle(1);

    // 8086 single, IC4: W3 skipped
    wr(0, 8'h13); wr(1, 8'h20);
    check("init_after_icw2", 32'(b0.init_done), 32'h0);
    wr(1, 8'h01);
    check("init_after_icw4", 32'(b0.init_done), 32'h1);
    cur_isr = 8'h04;
    lo(); check("p1_86_vec_oe", 32'(b0.vec_oe), 32'h0);
    idle(1); hi(); idle(1);
    lo(); check("p2_86_dout", 32'(b0.dout), 32'h22);
    check("p2_86_vec_oe", 32'(b0.vec_oe), 32'h1);
    idle(1); hi(); check("p2_86_off", 32'(b0.vec_oe), 32'h0);
    idle(2);

    // OCW1, OCW3, OCW2
    wr(1, 8'hF0); check("ocw1_imr", 32'(b0.imr), 32'hF0);
    wr(0, 8'h0B); check("ocw3_read_isr", 32'(b0.read_isr), 32'h1);
    wr(0, 8'h63); check("spec_eoi_p", 32'(b0.eoi_p), 32'h1);
    check("spec_eoi_lvl", 32'(b0.eoi_lvl), 32'h3);
    idle(1); check("eoi_one_cycle", 32'(b0.eoi_p), 32'h0);
    cur_isr = 8'h06;
    wr(0, 8'h20); check("ns_eoi_lvl", 32'(b0.eoi_lvl), 32'h1);
    cur_isr = 8'h00;
    wr(0, 8'h20); check("ns_eoi_empty", 32'(b0.eoi_p), 32'h0);
    wr(0, 8'hA0); idle(1);

    // ICW1 rewrite with AEOI
    wr(0, 8'h13);
    check("icw1_imr", 32'(b0.imr), 32'h5A);
    check("icw1_init_done", 32'(b0.init_done), 32'h0);
    wr(1, 8'h20); wr(1, 8'h03);
    cur_isr = 8'h10;
    lo(); hi(); lo(); check("aeoi_vec", 32'(b0.dout), 32'h24);
    hi(); check("aeoi_p", 32'(b0.eoi_p), 32'h1);
    check("aeoi_lvl", 32'(b0.eoi_lvl), 32'h4);
    idle(1); check("aeoi_one", 32'(b0.eoi_p), 32'h0);
    idle(1);
    // OCW2 EOI collides with the AEOI edge
    lo(); hi(); lo();
    cur_inta = 1'b1;
    wr(0, 8'h63); check("coll_first", 32'(b0.eoi_lvl), 32'h3);
    idle(1); check("coll_second_p", 32'(b0.eoi_p), 32'h1);
    check("coll_second_lvl", 32'(b0.eoi_lvl), 32'h4);
    idle(2);

    // ICW1 aborts ack between pulses and when coincident with an edge
    wr(0, 8'h13); wr(1, 8'h20); wr(1, 8'h01);
    lo(); hi();
    wr(0, 8'h13);
    lo(); check("abort_vec_oe", 32'(b0.vec_oe), 32'h0);
    hi(); wr(1, 8'h20); wr(1, 8'h01);
    lo(); hi();
    cur_inta = 1'b0;
    wr(0, 8'h13); check("coinc_vec_oe", 32'(b0.vec_oe), 32'h0);
    hi(); idle(1);

    // 8080 mode, interval 4
    wr(0, 8'h16); wr(1, 8'h10);
    check("m80_mode", 32'(b0.mode_8086), 32'h0);
    cur_isr = 8'h08;
    lo(); check("m80_p1", 32'(b0.dout), 32'hCD);
    hi(); check("m80_gap", 32'(b0.dout), 32'h00);
    lo(); check("m80_p2", 32'(b0.dout), 32'h0C);
    hi(); lo(); check("m80_p3", 32'(b0.dout), 32'h10);
    hi(); idle(1);

    // 8080 mode, interval 8, empty ISR
    wr(0, 8'h52); wr(1, 8'h10);
    cur_isr = 8'h00;
    lo(); hi(); lo(); check("m80_i8_empty", 32'(b0.dout), 32'h78);
    hi(); lo(); hi(); idle(1);

    // N_IRQ=4 vector, then asynchronous reset with vec_oe high
    wr(0, 8'h13); wr(1, 8'h48); wr(1, 8'h01);
    cur_isr = 8'h08;
    lo(); hi(); lo();
    check("n4_vector", 32'(b1.dout), 32'h4B);
    check("n4_vec_oe", 32'(b1.vec_oe), 32'h1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_vec_oe8", 32'(b0.vec_oe), 32'h0);
    check("arst_dout8", 32'(b0.dout), 32'h0);
    check("arst_vec_oe4", 32'(b1.vec_oe), 32'h0);
    check("arst_dout4", 32'(b1.dout), 32'h0);
    @(negedge clk);
    cur_inta = 1'b1;
    idle(2);
    reset_n = 1'b1;
    idle(3);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
